// File: rtl/mem_fill_arbiter.sv
`default_nettype none
// ============================================================================
// Module     : mem_fill_arbiter
// Description: Shares one pipelined main-memory port between I-cache fills,
//              D-cache fills and D-cache write-through stores. Grants one
//              requester at a time (store > D fill > I fill), issues block
//              reads word by word, steers returned words into the owning
//              cache and pulses a per-requester done strobe.
// Revision   : 1.0 - initial release
// ============================================================================
module mem_fill_arbiter #(
  parameter int ADDR_W        = 16,
  parameter int DATA_W        = 16,
  parameter int WORDS_PER_BLK = 8,
  parameter int MEM_LATENCY   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_miss,
  input  logic [ADDR_W-1:0] ic_miss_addr,
  input  logic              dc_miss,
  input  logic [ADDR_W-1:0] dc_miss_addr,
  input  logic              dc_wr_req,
  input  logic [ADDR_W-1:0] dc_wr_addr,
  input  logic [DATA_W-1:0] dc_wr_data,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] fill_addr,
  output logic [DATA_W-1:0] fill_data,
  output logic              ic_fill_we,
  output logic              dc_fill_we,
  output logic              ic_fill_done,
  output logic              dc_fill_done,
  output logic              dc_wr_done,
  output logic              busy
);

  localparam int CNT_W = $clog2(WORDS_PER_BLK) + 1;
  localparam logic [CNT_W-1:0]  c_words    = CNT_W'(WORDS_PER_BLK);
  localparam logic [CNT_W-1:0]  c_lastWord = CNT_W'(WORDS_PER_BLK - 1);
  // Clears the byte offset within a block (block = 2*WORDS_PER_BLK bytes).
  localparam logic [ADDR_W-1:0] c_blkMask  = ~ADDR_W'(2 * WORDS_PER_BLK - 1);

  // Reject configurations the counters and block alignment cannot support.
  if ((MEM_LATENCY < 1) || (WORDS_PER_BLK < 2) ||
      ((WORDS_PER_BLK & (WORDS_PER_BLK - 1)) != 0)) begin : g_paramCheck
    $error("mem_fill_arbiter: WORDS_PER_BLK must be a power of 2 >= 2 and MEM_LATENCY >= 1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    FILL  = 2'd2,
    DONE  = 2'd3
  } arbState_e;

  arbState_e         r_state;
  arbState_e         w_nextState;
  logic [CNT_W-1:0]  r_issueCnt;
  logic [CNT_W-1:0]  r_recvCnt;
  logic              r_ownerD;     // 1 = D-cache owns the fill, 0 = I-cache
  logic [ADDR_W-1:0] r_addr;       // store address, or block base for a fill
  logic [DATA_W-1:0] r_wdata;
  logic              w_issue;
  logic              w_recv;
  logic [ADDR_W-1:0] w_issueOff;
  logic [ADDR_W-1:0] w_recvOff;

  // Word index to byte offset (2 bytes per word).
  assign w_issueOff = ADDR_W'({r_issueCnt, 1'b0});
  assign w_recvOff  = ADDR_W'({r_recvCnt, 1'b0});
  assign busy       = (r_state != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  // Grant latching and issue/return word counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_issueCnt <= '0;
      r_recvCnt  <= '0;
      r_ownerD   <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_issueCnt <= '0;
          r_recvCnt  <= '0;
          if (dc_wr_req) begin
            r_addr  <= dc_wr_addr;
            r_wdata <= dc_wr_data;
          end else if (dc_miss) begin
            r_addr   <= dc_miss_addr & c_blkMask;
            r_ownerD <= 1'b1;
          end else if (ic_miss) begin
            r_addr   <= ic_miss_addr & c_blkMask;
            r_ownerD <= 1'b0;
          end
        end
        FILL: begin
          if (w_issue) r_issueCnt <= r_issueCnt + 1'b1;
          if (w_recv)  r_recvCnt  <= r_recvCnt + 1'b1;
        end
        default: begin
          r_issueCnt <= '0;
          r_recvCnt  <= '0;
        end
      endcase
    end
  end

  // Next-state and output decode; every output is zero unless its state drives it.
  always_comb begin
    w_nextState  = r_state;
    w_issue      = 1'b0;
    w_recv       = 1'b0;
    mem_en       = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    fill_addr    = '0;
    fill_data    = '0;
    ic_fill_we   = 1'b0;
    dc_fill_we   = 1'b0;
    ic_fill_done = 1'b0;
    dc_fill_done = 1'b0;
    dc_wr_done   = 1'b0;
    case (r_state)
      IDLE: begin
        if (dc_wr_req)               w_nextState = WRITE;
        else if (dc_miss || ic_miss) w_nextState = FILL;
      end
      WRITE: begin
        mem_en      = 1'b1;
        mem_wr      = 1'b1;
        mem_addr    = r_addr;
        mem_wdata   = r_wdata;
        dc_wr_done  = 1'b1;
        w_nextState = IDLE;
      end
      FILL: begin
        if (r_issueCnt < c_words) begin
          w_issue  = 1'b1;
          mem_en   = 1'b1;
          mem_addr = r_addr + w_issueOff;
        end
        // Returns arrive in issue order, so the receive count names the word.
        if (mem_valid && (r_recvCnt < c_words)) begin
          w_recv    = 1'b1;
          fill_addr = r_addr + w_recvOff;
          fill_data = mem_rdata;
          if (r_ownerD) dc_fill_we = 1'b1;
          else          ic_fill_we = 1'b1;
          if (r_recvCnt == c_lastWord) w_nextState = DONE;
        end
      end
      DONE: begin
        if (r_ownerD) dc_fill_done = 1'b1;
        else          ic_fill_done = 1'b1;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_fill_arbiter.sv
`default_nettype none
// ============================================================================
// Module     : tb_mem_fill_arbiter
// Description: Self-checking bench for mem_fill_arbiter with a 4-cycle
//              pipelined memory model returning (address ^ 0xA5A5).
// Revision   : 1.0 - initial release
// ============================================================================
module tb_mem_fill_arbiter;

  logic        clk, rst;
  logic        ic_miss, dc_miss, dc_wr_req;
  logic [15:0] ic_miss_addr, dc_miss_addr, dc_wr_addr, dc_wr_data;
  logic        mem_en, mem_wr, mem_valid;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, fill_addr, fill_data;
  logic        ic_fill_we, dc_fill_we, ic_fill_done, dc_fill_done, dc_wr_done, busy;

  logic        strayValid;
  logic [15:0] strayData;
  logic [3:0]  r_pv;
  logic [15:0] r_pa [4];

  int nChecks = 0;
  int nFail   = 0;

  mem_fill_arbiter #(
    .ADDR_W(16), .DATA_W(16), .WORDS_PER_BLK(8), .MEM_LATENCY(4)
  ) dut (
    .clk(clk), .rst(rst),
    .ic_miss(ic_miss), .ic_miss_addr(ic_miss_addr),
    .dc_miss(dc_miss), .dc_miss_addr(dc_miss_addr),
    .dc_wr_req(dc_wr_req), .dc_wr_addr(dc_wr_addr), .dc_wr_data(dc_wr_data),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_valid(mem_valid), .mem_rdata(mem_rdata),
    .fill_addr(fill_addr), .fill_data(fill_data),
    .ic_fill_we(ic_fill_we), .dc_fill_we(dc_fill_we),
    .ic_fill_done(ic_fill_done), .dc_fill_done(dc_fill_done),
    .dc_wr_done(dc_wr_done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pipelined memory: a read issued in cycle N returns in cycle N+4.
  always @(posedge clk) begin
    if (rst) begin
      r_pv <= 4'b0;
    end else begin
      r_pv    <= {r_pv[2:0], mem_en & ~mem_wr};
      r_pa[0] <= mem_addr;
      for (int i = 1; i < 4; i++) r_pa[i] <= r_pa[i-1];
    end
  end
  assign mem_valid = r_pv[3] | strayValid;
  assign mem_rdata = strayValid ? strayData : (r_pv[3] ? (r_pa[3] ^ 16'hA5A5) : 16'h0000);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s @%0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Every output must be zero (idle, reset or after an aborted transfer).
  task automatic chkIdle(input string tag);
    chk1({tag, ".mem_en"}, mem_en, 1'b0);
    chk1({tag, ".mem_wr"}, mem_wr, 1'b0);
    chk16({tag, ".mem_addr"}, mem_addr, 16'h0);
    chk16({tag, ".mem_wdata"}, mem_wdata, 16'h0);
    chk16({tag, ".fill_addr"}, fill_addr, 16'h0);
    chk16({tag, ".fill_data"}, fill_data, 16'h0);
    chk1({tag, ".ic_fill_we"}, ic_fill_we, 1'b0);
    chk1({tag, ".dc_fill_we"}, dc_fill_we, 1'b0);
    chk1({tag, ".ic_fill_done"}, ic_fill_done, 1'b0);
    chk1({tag, ".dc_fill_done"}, dc_fill_done, 1'b0);
    chk1({tag, ".dc_wr_done"}, dc_wr_done, 1'b0);
    chk1({tag, ".busy"}, busy, 1'b0);
  endtask

  // Current cycle is T (request visible in IDLE); checks cycles T..T+13.
  task automatic expectFill(input string tag, input logic isD, input logic [15:0] base);
    for (int k = 0; k < 14; k++) begin
      logic        eEn, eWe, eDone;
      logic [15:0] eAddr, eFa;
      eEn   = (k >= 1 && k <= 8);
      eAddr = eEn ? base + 16'(2 * (k - 1)) : 16'h0;
      eWe   = (k >= 5 && k <= 12);
      eFa   = eWe ? base + 16'(2 * (k - 5)) : 16'h0;
      eDone = (k == 13);
      @(negedge clk);
      chk1({tag, ".mem_en"}, mem_en, eEn);
      chk1({tag, ".mem_wr"}, mem_wr, 1'b0);
      chk16({tag, ".mem_addr"}, mem_addr, eAddr);
      chk1({tag, ".ic_fill_we"}, ic_fill_we, !isD && eWe);
      chk1({tag, ".dc_fill_we"}, dc_fill_we, isD && eWe);
      chk16({tag, ".fill_addr"}, fill_addr, eFa);
      chk16({tag, ".fill_data"}, fill_data, eWe ? (eFa ^ 16'hA5A5) : 16'h0);
      chk1({tag, ".ic_fill_done"}, ic_fill_done, !isD && eDone);
      chk1({tag, ".dc_fill_done"}, dc_fill_done, isD && eDone);
      chk1({tag, ".dc_wr_done"}, dc_wr_done, 1'b0);
      chk1({tag, ".busy"}, busy, k != 0);
      tick();
    end
  endtask

  typedef struct {
    logic        icMiss;
    logic        memEn;
    logic [15:0] memAddr;
    logic        icWe;
    logic [15:0] fillAddr;
    logic        icDone;
    logic        busy;
  } vec_t;

  vec_t tbl [15];

  // Watchdog: the directed sequence is a few hundred cycles.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    // I-cache fill of 0x123A, cycle T+0 .. T+14 (hand-derived timeline).
    tbl[0]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 16'h1230, 1'b0, 16'h0000, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 1'b1, 16'h1232, 1'b0, 16'h0000, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 1'b1, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 1'b1, 16'h1236, 1'b0, 16'h0000, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 1'b1, 16'h1238, 1'b1, 16'h1230, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 1'b1, 16'h123A, 1'b1, 16'h1232, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 1'b1, 16'h123C, 1'b1, 16'h1234, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 1'b1, 16'h123E, 1'b1, 16'h1236, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h1238, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h123A, 1'b0, 1'b1};
    tbl[11] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h123C, 1'b0, 1'b1};
    tbl[12] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h123E, 1'b0, 1'b1};
    tbl[13] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[14] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};

    rst = 1'b1;
    ic_miss = 1'b0; dc_miss = 1'b0; dc_wr_req = 1'b0;
    ic_miss_addr = 16'h0; dc_miss_addr = 16'h0; dc_wr_addr = 16'h0; dc_wr_data = 16'h0;
    strayValid = 1'b0; strayData = 16'h0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chkIdle("reset");
    tick();

    // Table-driven single I-cache fill.
    ic_miss_addr = 16'h123A;
    for (int k = 0; k < 15; k++) begin
      ic_miss = tbl[k].icMiss;
      @(negedge clk);
      chk1("tbl.mem_en", mem_en, tbl[k].memEn);
      chk1("tbl.mem_wr", mem_wr, 1'b0);
      chk16("tbl.mem_addr", mem_addr, tbl[k].memAddr);
      chk1("tbl.ic_fill_we", ic_fill_we, tbl[k].icWe);
      chk1("tbl.dc_fill_we", dc_fill_we, 1'b0);
      chk16("tbl.fill_addr", fill_addr, tbl[k].fillAddr);
      chk16("tbl.fill_data", fill_data, tbl[k].icWe ? (tbl[k].fillAddr ^ 16'hA5A5) : 16'h0);
      chk1("tbl.ic_fill_done", ic_fill_done, tbl[k].icDone);
      chk1("tbl.dc_fill_done", dc_fill_done, 1'b0);
      chk1("tbl.busy", busy, tbl[k].busy);
      tick();
    end

    // Stray mem_valid while idle is ignored.
    strayValid = 1'b1; strayData = 16'hDEAD;
    @(negedge clk);
    chkIdle("stray");
    tick();
    strayValid = 1'b0; strayData = 16'h0;
    @(negedge clk);
    chkIdle("stray.after");
    tick();

    // Simultaneous D and I misses: D first, I granted after DONE + IDLE.
    dc_miss = 1'b1; dc_miss_addr = 16'h4006;
    ic_miss = 1'b1; ic_miss_addr = 16'h0010;
    expectFill("prioD", 1'b1, 16'h4000);
    dc_miss = 1'b0;
    expectFill("prioI", 1'b0, 16'h0010);
    ic_miss = 1'b0;

    // Store ahead of a pending D fill.
    dc_wr_req = 1'b1; dc_wr_addr = 16'h2002; dc_wr_data = 16'hBEEF;
    dc_miss = 1'b1; dc_miss_addr = 16'h3004;
    @(negedge clk);
    chk1("wr.grantcycle.busy", busy, 1'b0);
    chk1("wr.grantcycle.mem_en", mem_en, 1'b0);
    tick();
    @(negedge clk);
    chk1("wr.mem_en", mem_en, 1'b1);
    chk1("wr.mem_wr", mem_wr, 1'b1);
    chk16("wr.mem_addr", mem_addr, 16'h2002);
    chk16("wr.mem_wdata", mem_wdata, 16'hBEEF);
    chk1("wr.dc_wr_done", dc_wr_done, 1'b1);
    chk1("wr.dc_fill_we", dc_fill_we, 1'b0);
    chk1("wr.busy", busy, 1'b1);
    tick();
    dc_wr_req = 1'b0; dc_wr_addr = 16'h0; dc_wr_data = 16'h0;
    expectFill("wrThenD", 1'b1, 16'h3000);
    dc_miss = 1'b0;

    // Reset during the 5th issue cycle of a D fill.
    dc_miss = 1'b1; dc_miss_addr = 16'h5000;
    @(negedge clk);
    chk1("rstmid.T.busy", busy, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      @(negedge clk);
      chk1("rstmid.issue.mem_en", mem_en, 1'b1);
      chk16("rstmid.issue.mem_addr", mem_addr, 16'h5000 + 16'(2 * (k - 1)));
    end
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk1("rstmid.5th.mem_en", mem_en, 1'b1);
    chk16("rstmid.5th.mem_addr", mem_addr, 16'h5008);
    tick();
    rst = 1'b0; dc_miss = 1'b0;
    @(negedge clk);
    chkIdle("rstmid.after");
    for (int k = 0; k < 8; k++) begin
      tick();
      @(negedge clk);
      chk1("rstmid.quiet.dc_fill_we", dc_fill_we, 1'b0);
      chk1("rstmid.quiet.dc_fill_done", dc_fill_done, 1'b0);
      chk1("rstmid.quiet.busy", busy, 1'b0);
    end
    tick();
    ic_miss = 1'b1; ic_miss_addr = 16'h0040;
    expectFill("rstmid.fresh", 1'b0, 16'h0040);
    ic_miss = 1'b0;

    // Back-to-back I fills with ic_miss held across done.
    ic_miss = 1'b1; ic_miss_addr = 16'h0000;
    expectFill("b2b.first", 1'b0, 16'h0000);
    ic_miss_addr = 16'h0010;
    expectFill("b2b.second", 1'b0, 16'h0010);
    ic_miss = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chkIdle("b2b.after");
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
`default_nettype wire
